// File: rtl/core_pkg.sv
// ----------------------------------------------------------------------------
// core_pkg
// Shared constants and types for the integer core.
//   NUM_REGS_DEFAULT : architectural register count (32 for RV32I, 16 for RV32E)
//   REG_ADDR_W       : register address width derived from NUM_REGS_DEFAULT
//   XLEN_DEFAULT     : integer data width
//   reg_addr_t       : register address type
// ----------------------------------------------------------------------------
package core_pkg;

    localparam int NUM_REGS_DEFAULT = 32;
    localparam int REG_ADDR_W       = $clog2(NUM_REGS_DEFAULT);
    localparam int XLEN_DEFAULT     = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage : core_pkg

// File: rtl/core_reg_file_scoreboard.sv
// ----------------------------------------------------------------------------
// core_scoreboard
// One busy bit per architectural register, tracking writes that have issued
// but not yet been written back. Detects RAW (rs1/rs2) and WAW (rd) hazards
// against those in-flight writes and raises the decode stall.
//   clk, rst           : clock, asynchronous active-high reset
//   i_rs1_*, i_rs2_*   : source addresses and "source is read" enables
//   i_issue_valid      : instruction leaving decode this cycle
//   i_issue_rd         : destination of the issuing instruction
//   i_issue_write      : issuing instruction writes its destination
//   i_reg_d_write/addr : writeback port (clears busy, unblocks same cycle)
//   i_flush            : discard every in-flight write
//   o_stall            : hazard, decode holds the instruction
// ----------------------------------------------------------------------------
module core_scoreboard
    import core_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEFAULT,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] i_rs1_addr,
    input  logic          i_rs1_used,
    input  logic [AW-1:0] i_rs2_addr,
    input  logic          i_rs2_used,
    input  logic          i_issue_valid,
    input  logic [AW-1:0] i_issue_rd,
    input  logic          i_issue_write,
    input  logic          i_reg_d_write,
    input  logic [AW-1:0] i_reg_d_addr,
    input  logic          i_flush,
    output logic          o_stall
);

    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_next;
    logic                w_rs1_busy;
    logic                w_rs2_busy;
    logic                w_rd_busy;
    logic                w_raw1;
    logic                w_raw2;
    logic                w_waw;
    logic                w_stall;
    logic                w_issue_fire;

    // Busy lookup. The loop starts at 1 so x0 never reads busy, and addresses
    // at or above NUM_REGS match nothing and read not-busy.
    // NOTE: every always_comb output gets a default before any branch so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        w_rs1_busy = 1'b0;
        w_rs2_busy = 1'b0;
        w_rd_busy  = 1'b0;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (i_rs1_addr == AW'(r)) w_rs1_busy = r_busy[r];
            if (i_rs2_addr == AW'(r)) w_rs2_busy = r_busy[r];
            if (i_issue_rd == AW'(r)) w_rd_busy  = r_busy[r];
        end
    end

    // A writeback landing this cycle resolves the hazard on its register
    // immediately: the read port bypasses the data to the reader.
    assign w_raw1 = i_rs1_used && w_rs1_busy &&
                    !(i_reg_d_write && i_reg_d_addr == i_rs1_addr);
    assign w_raw2 = i_rs2_used && w_rs2_busy &&
                    !(i_reg_d_write && i_reg_d_addr == i_rs2_addr);
    assign w_waw  = i_issue_write && w_rd_busy &&
                    !(i_reg_d_write && i_reg_d_addr == i_issue_rd);

    assign w_stall      = i_issue_valid && !i_flush && (w_raw1 || w_raw2 || w_waw);
    assign w_issue_fire = i_issue_valid && !w_stall && !i_flush;
    assign o_stall      = w_stall;

    // Set beats clear: an instruction issuing to rd in the same cycle that the
    // previous write to rd retires leaves rd busy for the new write.
    always_comb begin
        w_busy_next = r_busy;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (w_issue_fire && i_issue_write && i_issue_rd == AW'(r)) begin
                w_busy_next[r] = 1'b1;
            end else if (i_reg_d_write && i_reg_d_addr == AW'(r)) begin
                w_busy_next[r] = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else if (i_flush) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

endmodule : core_scoreboard

// File: rtl/core_reg_file.sv
// ----------------------------------------------------------------------------
// core_reg_file
// Integer register file at the consumer end of writeback. Two combinational,
// write-first read ports feed decode/EXEC; a busy scoreboard stalls decode on
// hazards against writes still in flight.
//   clk, rst                       : clock, asynchronous active-high reset
//   rs1_addr/used, rs1_value       : read port 1 (+ hazard enable)
//   rs2_addr/used, rs2_value       : read port 2 (+ hazard enable)
//   issue_valid/rd/write           : instruction leaving decode
//   reg_d_write/addr/value         : writeback port from the WB mux
//   flush                          : trap/redirect, drop in-flight writes
//   stall                          : decode must hold the instruction
// x0 is hardwired to zero; addresses >= NUM_REGS write nothing and read zero.
// ----------------------------------------------------------------------------
module core_reg_file
    import core_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int NUM_REGS = NUM_REGS_DEFAULT,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1_addr,
    input  logic            rs1_used,
    output logic [XLEN-1:0] rs1_value,
    input  logic [AW-1:0]   rs2_addr,
    input  logic            rs2_used,
    output logic [XLEN-1:0] rs2_value,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    input  logic            issue_write,
    input  logic            reg_d_write,
    input  logic [AW-1:0]   reg_d_addr,
    input  logic [XLEN-1:0] reg_d_value,
    input  logic            flush,
    output logic            stall
);

    // x0 has no storage at all; entries 1..NUM_REGS-1 only.
    logic [XLEN-1:0] r_regs [1:NUM_REGS-1];

    logic w_bypass_rs1;
    logic w_bypass_rs2;

    // NOTE: the storage array is reset because architectural state must read
    // zero after reset; this keeps it in flops rather than a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                r_regs[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (reg_d_write && reg_d_addr == AW'(r)) begin
                    r_regs[r] <= reg_d_value;
                end
            end
        end
    end

    assign w_bypass_rs1 = reg_d_write && (reg_d_addr == rs1_addr);
    assign w_bypass_rs2 = reg_d_write && (reg_d_addr == rs2_addr);

    // Read mux: only addresses 1..NUM_REGS-1 select anything, which gives
    // x0 and out-of-range reads their zero value and keeps the bypass from
    // leaking dropped writes.
    always_comb begin
        rs1_value = '0;
        rs2_value = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (rs1_addr == AW'(r)) rs1_value = w_bypass_rs1 ? reg_d_value : r_regs[r];
            if (rs2_addr == AW'(r)) rs2_value = w_bypass_rs2 ? reg_d_value : r_regs[r];
        end
    end

    core_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .AW       (AW)
    ) u_scoreboard (
        .clk           (clk),
        .rst           (rst),
        .i_rs1_addr    (rs1_addr),
        .i_rs1_used    (rs1_used),
        .i_rs2_addr    (rs2_addr),
        .i_rs2_used    (rs2_used),
        .i_issue_valid (issue_valid),
        .i_issue_rd    (issue_rd),
        .i_issue_write (issue_write),
        .i_reg_d_write (reg_d_write),
        .i_reg_d_addr  (reg_d_addr),
        .i_flush       (flush),
        .o_stall       (stall)
    );

endmodule : core_reg_file
